// File: rtl/freq_meter_mc.sv
// freq_meter_mc: multi-channel gated event counter with saturation flags.
// Define FREQ_METER_EDGE_DETECT_EN to count rising edges of ce instead of levels.
module freq_meter_mc #(
  parameter int WIDTH       = 16,
  parameter int CHANNELS    = 4,
  parameter int GATE_CYCLES = 1000,
  parameter int EXT_GATE    = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       ce,
  input  logic                      ovf,
  output logic [CHANNELS*WIDTH-1:0] freq,
  output logic [CHANNELS-1:0]       sat,
  output logic                      valid
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GLAST = GW'(GATE_CYCLES - 1);
  localparam logic [WIDTH-1:0] MAX = '1;

  logic [GW-1:0]       r_gcnt;
  logic                w_gate;
  logic [CHANNELS-1:0] w_ev;
  logic [WIDTH-1:0]    r_cnt  [CHANNELS];
  logic [WIDTH-1:0]    w_next [CHANNELS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gcnt <= '0;
    end else if (r_gcnt == GLAST) begin
      r_gcnt <= '0;
    end else begin
      r_gcnt <= r_gcnt + 1'b1;
    end
  end

  assign w_gate = (EXT_GATE != 0) ? ovf : (r_gcnt == GLAST);

`ifdef FREQ_METER_EDGE_DETECT_EN
  logic [CHANNELS-1:0] r_ce_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ce_q <= '0;
    end else begin
      r_ce_q <= ce;
    end
  end

  assign w_ev = ce & ~r_ce_q;
`else
  assign w_ev = ce;
`endif

  // Saturating increment; the gate-cycle event still belongs to the closing window.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_next[i] = r_cnt[i];
      if (r_cnt[i] != MAX) begin
        w_next[i] = r_cnt[i] + WIDTH'(w_ev[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_cnt[i] <= '0;
      end
      freq  <= '0;
      sat   <= '0;
      valid <= 1'b0;
    end else begin
      valid <= w_gate;
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_gate) begin
          r_cnt[i]               <= '0;
          freq[i*WIDTH +: WIDTH] <= w_next[i];
          sat[i]                 <= (w_next[i] == MAX);
        end else begin
          r_cnt[i] <= w_next[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_freq_meter_mc.sv
// tb_freq_meter_mc: scoreboard bench for freq_meter_mc with three
// instances (internal gate 8, internal gate 20, external gate).
module tb_freq_meter_mc;

`ifdef FREQ_METER_EDGE_DETECT_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  typedef struct {
    int         due;
    logic [9:0] v;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic       rst0, rstb;
  logic       zero = 1'b0;
  logic       ovf2;
  logic [1:0] ce0, ce1, ce2;
  logic [7:0] f0, f1, f2;
  logic [1:0] s0, s1, s2;
  logic       v0, v1, v2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  logic [9:0] last0 = '0;

  freq_meter_mc #(.WIDTH(4), .CHANNELS(2), .GATE_CYCLES(8), .EXT_GATE(0)) u0 (
    .clk(clk), .rst(rst0), .ce(ce0), .ovf(zero),
    .freq(f0), .sat(s0), .valid(v0)
  );

  freq_meter_mc #(.WIDTH(4), .CHANNELS(2), .GATE_CYCLES(20), .EXT_GATE(0)) u1 (
    .clk(clk), .rst(rstb), .ce(ce1), .ovf(zero),
    .freq(f1), .sat(s1), .valid(v1)
  );

  freq_meter_mc #(.WIDTH(4), .CHANNELS(2), .GATE_CYCLES(8), .EXT_GATE(1)) u2 (
    .clk(clk), .rst(rstb), .ce(ce2), .ovf(ovf2),
    .freq(f2), .sat(s2), .valid(v2)
  );

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
               nm, act, req, cyc);
    end
  endtask

  function automatic exp_t mk(input int due, input int sv,
                              input int c1, input int c0);
    exp_t e;
    e.due = due;
    e.v   = {2'(sv), 4'(c1), 4'(c0)};
    return e;
  endfunction

  // One 8-cycle window on u0; bit c of p0/p1 drives cycle c.
  task automatic win(input logic [7:0] p0, input logic [7:0] p1,
                     input int l0, input int l1,
                     input int e0, input int e1);
    if (EDGE) q0.push_back(mk(cyc + 8, 0, e1, e0));
    else      q0.push_back(mk(cyc + 8, 0, l1, l0));
    for (int c = 0; c < 8; c++) begin
      ce0 = {p1[c], p0[c]};
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst0) begin
      last0 = '0;
    end else if (v0) begin
      if (q0.size() == 0) begin
        chk("u0_unexpected_valid", 1, 0);
      end else begin
        e = q0.pop_front();
        chk("u0_latency", cyc, e.due);
        chk("u0_value", {s0, f0}, e.v);
        last0 = e.v;
      end
    end else begin
      chk("u0_hold", {s0, f0}, last0);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rstb && v1) begin
      if (q1.size() == 0) begin
        chk("u1_unexpected_valid", 1, 0);
      end else begin
        e = q1.pop_front();
        chk("u1_latency", cyc, e.due);
        chk("u1_value", {s1, f1}, e.v);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rstb && v2) begin
      if (q2.size() == 0) begin
        chk("u2_unexpected_valid", 1, 0);
      end else begin
        e = q2.pop_front();
        chk("u2_latency", cyc, e.due);
        chk("u2_value", {s2, f2}, e.v);
      end
    end
  end

  initial begin
    rst0 = 1'b1;
    rstb = 1'b1;
    ce0  = 2'b00;
    ce1  = 2'b01;
    ce2  = 2'b10;
    ovf2 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_freq", f0, 0);
    chk("reset_sat", s0, 0);
    chk("reset_valid", v0, 0);
    @(negedge clk);
    rst0 = 1'b0;
    rstb = 1'b0;

    if (EDGE) begin
      q1.push_back(mk(cyc + 20, 0, 0, 1));
      q1.push_back(mk(cyc + 40, 0, 0, 0));
      q1.push_back(mk(cyc + 60, 0, 0, 0));
      q2.push_back(mk(cyc + 5, 0, 1, 0));
      q2.push_back(mk(cyc + 10, 0, 0, 0));
      q2.push_back(mk(cyc + 15, 0, 0, 0));
      q2.push_back(mk(cyc + 20, 0, 0, 0));
      q2.push_back(mk(cyc + 21, 0, 0, 0));
    end else begin
      q1.push_back(mk(cyc + 20, 1, 0, 15));
      q1.push_back(mk(cyc + 40, 1, 0, 15));
      q1.push_back(mk(cyc + 60, 1, 0, 15));
      q2.push_back(mk(cyc + 5, 0, 5, 0));
      q2.push_back(mk(cyc + 10, 0, 5, 0));
      q2.push_back(mk(cyc + 15, 0, 5, 0));
      q2.push_back(mk(cyc + 20, 0, 5, 0));
      q2.push_back(mk(cyc + 21, 0, 1, 0));
    end

    fork
      begin
        win(8'hFF, 8'h00, 8, 0, 1, 0);
        win(8'hFF, 8'h00, 8, 0, 0, 0);
        win(8'hAA, 8'h55, 4, 4, 4, 4);
        win(8'h80, 8'h00, 1, 0, 1, 0);
        win(8'h00, 8'hFF, 0, 8, 0, 1);
        win(8'h01, 8'hFF, 1, 8, 1, 0);
        ce0 = 2'b01;
        repeat (4) @(negedge clk);
        rst0 = 1'b1;
        #1;
        chk("midrst_freq", f0, 0);
        chk("midrst_sat", s0, 0);
        chk("midrst_valid", v0, 0);
        @(negedge clk);
        rst0 = 1'b0;
        win(8'hFF, 8'h00, 8, 0, 1, 0);
      end
      begin
        for (int k = 1; k <= 21; k++) begin
          ovf2 = (k % 5 == 0) || (k == 21);
          @(negedge clk);
        end
        ovf2 = 1'b0;
      end
      begin
        repeat (61) @(negedge clk);
        rstb = 1'b1;
      end
    join

    for (int i = 0; i < 50 && (q0.size() + q1.size() + q2.size()) > 0; i++)
      @(negedge clk);
    chk("u0_drained", q0.size(), 0);
    chk("u1_drained", q1.size(), 0);
    chk("u2_drained", q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
